// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: opcode and register encodings
// plus the instruction-word width calculation.
package ifu_pkg;

   typedef enum logic [3:0] {
      OP_LOAD = 4'b0000,
      OP_MOVE = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_XOR  = 4'b0011,
      OP_BR   = 4'b1000
   } opcode_e;

   typedef enum logic [2:0] {
      NA = 3'b000,
      R1 = 3'b001,
      R2 = 3'b010,
      R3 = 3'b011,
      R4 = 3'b100,
      R5 = 3'b101,
      R6 = 3'b110,
      PC = 3'b111
   } reg_code_e;

   function automatic int instr_w(input int op_size, input int arg_size, input int arg_num);
      return op_size + arg_num * arg_size;
   endfunction

endpackage

// File: rtl/ifu_return_stack.sv
// Bounded LIFO of return addresses. Callers must never push when full or pop when
// empty; overflow/underflow reporting belongs to the parent.
module ifu_return_stack
   import ifu_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  depth
);

   logic [CNT_W-1:0]  count_reg;
   logic [ADDR_W-1:0] stk_reg [DEPTH];
   logic [IDX_W-1:0]  wr_idx;
   logic [IDX_W-1:0]  top_idx;

   assign wr_idx  = IDX_W'(count_reg);
   assign top_idx = IDX_W'(count_reg - CNT_W'(1));

   // Entries are not reset; after rst the zero count makes them unreachable.
   always_ff @(posedge clk) begin
      if (push)
         stk_reg[wr_idx] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_reg <= '0;
      else if (push)
         count_reg <= count_reg + CNT_W'(1);
      else if (pop)
         count_reg <= count_reg - CNT_W'(1);
   end

   assign top   = stk_reg[top_idx];
   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);
   assign depth = count_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// Program store plus PC with branch, and call/ret through a hardware return stack
// when IFU_CALL_STACK_EN is defined (otherwise call acts as branch and ret is ignored).
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int OP_SIZE     = 4,
   parameter int ARG_SIZE    = 3,
   parameter int ARG_NUM     = 2,
   parameter int ADDR_W      = 4,
   parameter int STACK_DEPTH = 4,
   localparam int INSTR_W    = instr_w(OP_SIZE, ARG_SIZE, ARG_NUM),
   localparam int SD_W       = $clog2(STACK_DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               done,
   input  logic               branch,
   input  logic               call,
   input  logic               ret,
   input  logic [ADDR_W-1:0]  branch_addr,
   input  logic               prog_we,
   input  logic [ADDR_W-1:0]  prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  pc,
   output logic [SD_W-1:0]    stack_depth,
   output logic               stack_err
);

   logic [INSTR_W-1:0] mem [2**ADDR_W];
   logic [ADDR_W-1:0]  pc_reg;
   logic [ADDR_W-1:0]  pc_next;
   logic [ADDR_W-1:0]  pc_inc;

   assign pc_inc = pc_reg + ADDR_W'(1);

   // Store is deliberately left out of reset so programs survive a PC reset.
   always_ff @(posedge clk) begin
      if (prog_we)
         mem[prog_addr] <= prog_data;
   end

   assign instruction = mem[pc_reg];
   assign pc          = pc_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pc_reg <= '0;
      else
         pc_reg <= pc_next;
   end

`ifdef IFU_CALL_STACK_EN
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic              err_set;
   logic              stack_err_reg;
   logic [ADDR_W-1:0] top;

   // Lower-priority requests are masked so a dropped call/ret has no side effects.
   assign push    = call && !branch && !full;
   assign pop     = ret && !branch && !call && !empty;
   assign err_set = !branch && (call ? full : (ret && empty));

   ifu_return_stack #(
      .ADDR_W (ADDR_W),
      .DEPTH  (STACK_DEPTH)
   ) u_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .top       (top),
      .full      (full),
      .empty     (empty),
      .depth     (stack_depth)
   );

   always_comb begin
      pc_next = pc_reg;
      if (branch)
         pc_next = branch_addr;
      else if (call) begin
         if (!full)
            pc_next = branch_addr;
      end
      else if (ret) begin
         if (!empty)
            pc_next = top;
      end
      else if (done)
         pc_next = pc_inc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         stack_err_reg <= 1'b0;
      else if (err_set)
         stack_err_reg <= 1'b1;
   end

   assign stack_err = stack_err_reg;
`else
   logic unused_ret;

   assign unused_ret = ret;

   always_comb begin
      pc_next = pc_reg;
      if (branch || call)
         pc_next = branch_addr;
      else if (done)
         pc_next = pc_inc;
   end

   assign stack_depth = '0;
   assign stack_err   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; expectations follow IFU_CALL_STACK_EN when defined.
module tb_instr_fetch_unit;

   localparam int ADDR_W  = 4;
   localparam int INSTR_W = 10;
   localparam int SD_W    = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               done, branch, call, ret;
   logic [ADDR_W-1:0]  branch_addr;
   logic               prog_we;
   logic [ADDR_W-1:0]  prog_addr;
   logic [INSTR_W-1:0] prog_data;
   logic [INSTR_W-1:0] instruction;
   logic [ADDR_W-1:0]  pc;
   logic [SD_W-1:0]    stack_depth;
   logic               stack_err;

   int checks   = 0;
   int failures = 0;

   instr_fetch_unit #(
      .OP_SIZE     (4),
      .ARG_SIZE    (3),
      .ARG_NUM     (2),
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .done        (done),
      .branch      (branch),
      .call        (call),
      .ret         (ret),
      .branch_addr (branch_addr),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .instruction (instruction),
      .pc          (pc),
      .stack_depth (stack_depth),
      .stack_err   (stack_err)
   );

   always #5 clk = ~clk;

   function automatic logic [INSTR_W-1:0] word(input int i);
      return INSTR_W'(32'h2A5 ^ (i * 73));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One request cycle: drive on the falling edge, sample 1 ns after the rising edge.
   task automatic cyc(input logic d, input logic b, input logic c, input logic r,
                      input logic [ADDR_W-1:0] a);
      @(negedge clk);
      done = d; branch = b; call = c; ret = r; branch_addr = a;
      @(posedge clk);
      #1;
      done = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
   endtask

   task automatic wr(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
      @(negedge clk);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      @(posedge clk);
      #1;
      prog_we = 1'b0;
   endtask

   task automatic async_reset_check(input string tag);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk({tag, "_pc"}, 32'(pc), 32'd0);
      chk({tag, "_depth"}, 32'(stack_depth), 32'd0);
      chk({tag, "_err"}, 32'(stack_err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      done = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
      branch_addr = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;

      for (int i = 0; i < 16; i++)
         wr(ADDR_W'(i), word(i));
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_depth", 32'(stack_depth), 32'd0);
      chk("rst_err", 32'(stack_err), 32'd0);
      chk("rst_instr", 32'(instruction), 32'(word(0)));
      @(negedge clk);
      rst = 1'b0;

      for (int i = 1; i <= 5; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
         chk($sformatf("done_pc%0d", i), 32'(pc), 32'(i));
         chk($sformatf("done_instr%0d", i), 32'(instruction), 32'(word(i)));
      end

      cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd15);
      chk("br15_pc", 32'(pc), 32'd15);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      chk("wrap_pc", 32'(pc), 32'd0);
      chk("wrap_instr", 32'(instruction), 32'(word(0)));

      cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd3);
      chk("br3_pc", 32'(pc), 32'd3);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd10);
      chk("call10_pc", 32'(pc), 32'd10);

`ifdef IFU_CALL_STACK_EN
      chk("call10_depth", 32'(stack_depth), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      chk("ret_pc", 32'(pc), 32'd4);
      chk("ret_depth", 32'(stack_depth), 32'd0);
      chk("ret_err", 32'(stack_err), 32'd0);

      // Nested calls from pc=4 push 5,2,3,4; the fifth overflows.
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b0, 1'b0, 1'b1, 1'b0, ADDR_W'(i));
         chk($sformatf("nest%0d_pc", i), 32'(pc), 32'(i));
         chk($sformatf("nest%0d_depth", i), 32'(stack_depth), 32'(i));
      end
      chk("nest4_err", 32'(stack_err), 32'd0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd5);
      chk("ovf_pc", 32'(pc), 32'd4);
      chk("ovf_depth", 32'(stack_depth), 32'd4);
      chk("ovf_err", 32'(stack_err), 32'd1);

      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      chk("pop1_pc", 32'(pc), 32'd4);
      chk("pop1_depth", 32'(stack_depth), 32'd3);
      chk("pop1_err", 32'(stack_err), 32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      chk("pop2_pc", 32'(pc), 32'd3);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      chk("pop3_pc", 32'(pc), 32'd2);
      chk("pop3_depth", 32'(stack_depth), 32'd1);

      cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd9);
      chk("brcall_pc", 32'(pc), 32'd9);
      chk("brcall_depth", 32'(stack_depth), 32'd1);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
      chk("doneret_pc", 32'(pc), 32'd5);
      chk("doneret_depth", 32'(stack_depth), 32'd0);
      chk("doneret_err", 32'(stack_err), 32'd1);

      async_reset_check("arst1");

      cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd7);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      chk("unf_pc", 32'(pc), 32'd7);
      chk("unf_err", 32'(stack_err), 32'd1);
      chk("unf_depth", 32'(stack_depth), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      chk("sticky_pc", 32'(pc), 32'd8);
      chk("sticky_err", 32'(stack_err), 32'd1);
`else
      chk("call10_depth", 32'(stack_depth), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
      chk("doneret_pc", 32'(pc), 32'd11);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
      chk("ret_ignored_pc", 32'(pc), 32'd11);
      chk("ret_ignored_err", 32'(stack_err), 32'd0);
      chk("ret_ignored_depth", 32'(stack_depth), 32'd0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'd9);
      chk("brcall_pc", 32'(pc), 32'd9);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd2);
      chk("calldone_pc", 32'(pc), 32'd2);
      chk("calldone_depth", 32'(stack_depth), 32'd0);

      async_reset_check("arst1");
`endif

      cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd6);
      chk("br6_pc", 32'(pc), 32'd6);
      chk("br6_instr", 32'(instruction), 32'(word(6)));

      prog_we = 1'b1; prog_addr = 4'd6; prog_data = 10'h3C1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      prog_we = 1'b0;
      chk("wrpc_instr", 32'(instruction), 32'h3C1);
      chk("wrpc_pc", 32'(pc), 32'd6);

      prog_we = 1'b1; prog_addr = 4'd7; prog_data = 10'h0F0;
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      prog_we = 1'b0;
      chk("wrdone_pc", 32'(pc), 32'd7);
      chk("wrdone_instr", 32'(instruction), 32'h0F0);

      wr(4'd2, 10'h155);
      chk("wrother_instr", 32'(instruction), 32'h0F0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
      chk("br2_instr", 32'(instruction), 32'h155);

      async_reset_check("arst2");
      chk("arst2_instr", 32'(instruction), 32'(word(0)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
